serial_neg_rx: RTL and testbench

SERIAL_NEG_RX -- requirements
Module: serial_neg_rx

---
 rtl/serial_neg_rx.sv | 96 +++++++++
 tb/tb_serial_neg_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_neg_rx.sv
//------------------------------------------------------------------------------
// serial_neg_rx: decodes an LSB-first two's-complement-negated serial stream
// into parallel words with a one-deep ready/valid output stage.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_neg_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             x_valid,
  input  logic             start,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COPY   = 2'd1,
    INVERT = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;

  logic             w_take;
  logic             w_bit;
  logic [CW-1:0]    w_idx;
  logic             w_last;
  logic             w_done;
  logic [WIDTH-1:0] w_sreg_nxt;
  state_t           w_state_nxt;

  // A qualified start always restarts at bit 0 under the COPY rule.
  always_comb begin
    w_take      = x_valid && (start || (state != IDLE));
    w_bit       = (state == INVERT && !start) ? ~x : x;
    w_idx       = start ? '0 : cnt;
    w_last      = (w_idx == CW'(WIDTH - 1));
    w_done      = w_take && w_last;
    w_sreg_nxt  = start ? '0 : sreg;
    w_sreg_nxt[w_idx] = w_bit;
    if (w_last)
      w_state_nxt = IDLE;
    else if (start || state != INVERT)
      w_state_nxt = x ? INVERT : COPY;
    else
      w_state_nxt = INVERT;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sreg      <= '0;
      dout      <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      if (w_take) begin
        frame_err <= start && (state != IDLE);
        sreg      <= w_sreg_nxt;
        state     <= w_state_nxt;
        cnt       <= w_last ? '0 : w_idx + 1'b1;
      end
      // Output slot holds one word; a completion into a stalled slot is dropped.
      if (w_done && (!out_valid || out_ready)) begin
        dout      <= w_sreg_nxt;
        ovf       <= (w_sreg_nxt == MOST_NEG);
        out_valid <= 1'b1;
      end else if (w_done) begin
        overrun   <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_neg_rx.sv
//------------------------------------------------------------------------------
// tb_serial_neg_rx: directed and randomized checks of serial_neg_rx against a
// arithmetic negation model.
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_neg_rx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         x = 1'b0;
  logic         x_valid = 1'b0;
  logic         start = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] dout;
  logic         out_valid;
  logic         ovf;
  logic         overrun;
  logic         frame_err;

  int checks = 0;
  int failures = 0;
  int ov_cnt = 0;
  int fe_cnt = 0;

  serial_neg_rx #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .x_valid   (x_valid),
    .start     (start),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] neg(input logic [W-1:0] w);
    logic [W-1:0] r;
    r = -w;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic xb);
    x_valid = v;
    start   = s;
    x       = xb;
    @(posedge clk);
    #1;
    ov_cnt += int'(overrun);
    fe_cnt += int'(frame_err);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dout"}, 32'(dout), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_ovf"}, 32'(ovf), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
    chk({tag, "_frame_err"}, 32'(frame_err), 0);
  endtask

  task automatic expect_word(input string tag, input logic [W-1:0] w);
    logic [W-1:0] e;
    e = neg(w);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_dout"}, 32'(dout), 32'(e));
    chk({tag, "_ovf"}, 32'(ovf), (e == (1 << (W - 1))) ? 1 : 0);
  endtask

  // gap_mode: 0 none, 1 one idle cycle between valid bits, 2 random idle cycles
  task automatic send_frame(input logic [W-1:0] w, input int gap_mode,
                            input logic rdy_body, input logic rdy_last, input int first);
    for (int i = first; i < W; i++) begin
      out_ready = rdy_body;
      if (gap_mode == 1 && i > first)
        step(1'b0, 1'($urandom), 1'($urandom));
      else if (gap_mode == 2)
        repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom), 1'($urandom));
      if (i == W - 1) begin
        out_ready = rdy_last;
        if (rdy_body && first < W - 2)
          chk("early_valid", 32'(out_valid), 0);
      end
      step(1'b1, i == 0, w[i]);
    end
    x_valid = 1'b0;
    start   = 1'b0;
  endtask

  initial begin
    logic [W-1:0] a, b, c, w;
    int ov0, fe0;

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    #2 rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);  // no start: must be ignored
    chk("idle_ignore", 32'(out_valid), 0);

    send_frame(8'hFB, 0, 1'b1, 1'b1, 0);
    expect_word("fb", 8'hFB);
    chk("fb_dout_lit", 32'(dout), 32'h05);
    step(1'b0, 1'b0, 1'b0);
    chk("consumed", 32'(out_valid), 0);

    send_frame(8'h80, 0, 1'b1, 1'b1, 0);
    expect_word("w80", 8'h80);
    chk("w80_ovf_lit", 32'(ovf), 1);
    send_frame(8'h00, 0, 1'b1, 1'b1, 0);
    expect_word("w00", 8'h00);

    send_frame(8'h01, 1, 1'b1, 1'b1, 0);
    expect_word("toggle", 8'h01);
    chk("toggle_lit", 32'(dout), 32'hFF);

    a = 8'h3C; b = 8'h11; c = 8'h96;
    step(1'b0, 1'b0, 1'b0);
    ov0 = ov_cnt;
    send_frame(a, 0, 1'b0, 1'b0, 0);
    expect_word("ovr_a", a);
    send_frame(b, 0, 1'b0, 1'b0, 0);
    chk("ovr_pulse", 32'(overrun), 1);
    expect_word("ovr_hold", a);
    step(1'b0, 1'b0, 1'b0);
    chk("ovr_once", 32'(overrun), 0);
    chk("ovr_count", 32'(ov_cnt - ov0), 1);
    send_frame(c, 0, 1'b0, 1'b1, 0);
    expect_word("ovr_c", c);
    chk("ovr_c_no_pulse", 32'(overrun), 0);
    out_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("ovr_drain", 32'(out_valid), 0);

    fe0 = fe_cnt;
    w = 8'h5A;
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, w[i]);
    chk("fe_quiet", 32'(frame_err), 0);
    w = 8'hFB;
    step(1'b1, 1'b1, w[0]);
    chk("fe_pulse", 32'(frame_err), 1);
    send_frame(8'hFB, 0, 1'b1, 1'b1, 1);
    chk("fe_count", 32'(fe_cnt - fe0), 1);
    expect_word("fe", 8'hFB);

    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, i == 0, 1'($urandom));
    #2 rst_n = 1'b1;
    #1 chk_zero("rst_mid");
    rst_n = 1'b0;
    send_frame(8'h5A, 0, 1'b0, 1'b0, 0);
    expect_word("pend", 8'h5A);
    #2 rst_n = 1'b1;
    #1 chk_zero("rst_pend");
    rst_n = 1'b0;
    out_ready = 1'b1;
    send_frame(8'h02, 0, 1'b1, 1'b1, 0);
    expect_word("post_rst", 8'h02);
    chk("post_rst_lit", 32'(dout), 32'hFE);

    for (int n = 0; n < 24; n++) begin
      w = (n % 8 == 3) ? 8'h80 : W'($urandom);
      send_frame(w, int'($urandom_range(0, 2)), 1'b1, 1'b1, 0);
      expect_word("rand", w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
